// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: init ownership, then fixed-priority refresh > write > read bus grant.
// Optional SDRAM_ARB_RR_EN: alternate write/read when both request together.
module sdram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_WIDTH = 2
) (
  input  logic                  arb_clk,
  input  logic                  arb_rst,
  input  logic                  init_end,
  input  logic [3:0]            init_cmd,
  input  logic [BANK_WIDTH-1:0] init_bank,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic                  aref_req,
  input  logic                  aref_end,
  input  logic [3:0]            aref_cmd,
  input  logic [BANK_WIDTH-1:0] aref_bank,
  input  logic [ADDR_WIDTH-1:0] aref_addr,
  output logic                  aref_en,
  input  logic                  wr_req,
  input  logic                  wr_end,
  input  logic [3:0]            wr_cmd,
  input  logic [BANK_WIDTH-1:0] wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_sdram_en,
  output logic                  wr_en,
  input  logic                  rd_req,
  input  logic                  rd_end,
  input  logic [3:0]            rd_cmd,
  input  logic [BANK_WIDTH-1:0] rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  sdram_cke,
  output logic                  sdram_cs_n,
  output logic                  sdram_ras_n,
  output logic                  sdram_cas_n,
  output logic                  sdram_we_n,
  output logic [BANK_WIDTH-1:0] sdram_ba,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic                  sdram_dq_oe,
  output logic [DATA_WIDTH-1:0] sdram_dq_out
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state;
  state_t state_next;
  logic   pick_read;
  logic [3:0] cmd;

`ifdef SDRAM_ARB_RR_EN
  // 1 = read was the most recent write/read grant
  logic last_rd;

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      last_rd <= 1'b1;
    end else if (state == S_ARBIT) begin
      if (state_next == S_WRITE)     last_rd <= 1'b0;
      else if (state_next == S_READ) last_rd <= 1'b1;
    end
  end

  assign pick_read = ~last_rd;
`else
  assign pick_read = 1'b0;
`endif

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) state <= S_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (init_end) state_next = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)                 state_next = S_AREF;
        else if (wr_req && rd_req)    state_next = pick_read ? S_READ : S_WRITE;
        else if (wr_req)              state_next = S_WRITE;
        else if (rd_req)              state_next = S_READ;
      end
      S_AREF:  if (aref_end) state_next = S_ARBIT;
      S_WRITE: if (wr_end)   state_next = S_ARBIT;
      S_READ:  if (rd_end)   state_next = S_ARBIT;
      default: state_next = init_end ? S_ARBIT : S_INIT;
    endcase
  end

  // Grants are registered copies of the next state so they track state without req glitches.
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      aref_en <= (state_next == S_AREF);
      wr_en   <= (state_next == S_WRITE);
      rd_en   <= (state_next == S_READ);
    end
  end

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) sdram_cke <= 1'b0;
    else         sdram_cke <= 1'b1;
  end

  always_comb begin
    cmd          = CMD_NOP;
    sdram_ba     = '1;
    sdram_addr   = '1;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = '0;
    case (state)
      S_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_bank;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        cmd          = wr_cmd;
        sdram_ba     = wr_bank;
        sdram_addr   = wr_addr;
        sdram_dq_oe  = wr_sdram_en;
        sdram_dq_out = wr_data;
      end
      S_READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against an owner-tracking reference model, plus directed scenarios.
module tb_sdram_arbiter;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int BW = 2;

  logic          arb_clk = 1'b0;
  logic          arb_rst;
  logic          init_end;
  logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [BW-1:0] init_bank, aref_bank, wr_bank, rd_bank;
  logic [AW-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic          aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [DW-1:0] wr_data;
  logic          wr_sdram_en;
  logic          aref_en, wr_en, rd_en;
  logic          sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BW-1:0] sdram_ba;
  logic [AW-1:0] sdram_addr;
  logic          sdram_dq_oe;
  logic [DW-1:0] sdram_dq_out;

  sdram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_WIDTH(BW)) dut (
    .arb_clk(arb_clk), .arb_rst(arb_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_bank(aref_bank), .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_sdram_en(wr_sdram_en), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out)
  );

  always #5 arb_clk = ~arb_clk;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  // Reference model: who owns the bus. 0 init, 1 idle/NOP, 2 refresh, 3 write, 4 read.
  int owner;
  bit exp_cke;
  bit last_was_read;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    exp_cke = 1'b0;
    last_was_read = 1'b1;
  endtask

  task automatic model_edge();
    if (arb_rst) begin
      model_reset();
      return;
    end
    exp_cke = 1'b1;
    case (owner)
      0: if (init_end) owner = 1;
      1: begin
        if (aref_req) owner = 2;
        else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
          owner = last_was_read ? 3 : 4;
`else
          owner = 3;
`endif
        end
        else if (wr_req) owner = 3;
        else if (rd_req) owner = 4;
      end
      2: if (aref_end) owner = 1;
      3: if (wr_end)   owner = 1;
      4: if (rd_end)   owner = 1;
      default: owner = 1;
    endcase
    if (owner == 3) last_was_read = 1'b0;
    if (owner == 4) last_was_read = 1'b1;
  endtask

  task automatic check_all();
    logic [18:0]   pins;
    logic [DW:0]   dq;
    logic [2:0]    g;
    case (owner)
      0:       pins = {init_cmd, init_bank, init_addr};
      2:       pins = {aref_cmd, aref_bank, aref_addr};
      3:       pins = {wr_cmd, wr_bank, wr_addr};
      4:       pins = {rd_cmd, rd_bank, rd_addr};
      default: pins = {4'b0111, 2'b11, 13'h1fff};
    endcase
    g  = {owner == 2, owner == 3, owner == 4};
    dq = (owner == 3) ? {wr_sdram_en, wr_data} : '0;
    check("grant", {aref_en, wr_en, rd_en}, g);
    check("cke", sdram_cke, exp_cke);
    check("pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}, pins);
    check("dq", {sdram_dq_oe, sdram_dq_out}, dq);
  endtask

  task automatic tick();
    @(posedge arb_clk);
    edges++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic randomize_buses();
    init_cmd  = 4'($urandom);  init_bank = BW'($urandom);  init_addr = AW'($urandom);
    aref_cmd  = 4'($urandom);  aref_bank = BW'($urandom);  aref_addr = AW'($urandom);
    wr_cmd    = 4'($urandom);  wr_bank   = BW'($urandom);  wr_addr   = AW'($urandom);
    rd_cmd    = 4'($urandom);  rd_bank   = BW'($urandom);  rd_addr   = AW'($urandom);
    wr_data   = DW'($urandom); wr_sdram_en = 1'($urandom);
  endtask

  task automatic randomize_ctrl();
    aref_req = ($urandom_range(0, 7) == 0);
    wr_req   = ($urandom_range(0, 2) == 0);
    rd_req   = ($urandom_range(0, 2) == 0);
    aref_end = ($urandom_range(0, 5) == 0);
    wr_end   = ($urandom_range(0, 5) == 0);
    rd_end   = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    arb_rst = 1'b1; init_end = 1'b0;
    randomize_buses();
    init_cmd = 4'b0010;
    {aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = '0;
    model_reset();

    // Reset held for 5 edges: pins follow init, cke low, no grants
    #1;
    check("rst_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 4'b0010);
    check_all();
    repeat (5) tick();
    check("rst_cke", sdram_cke, 1'b0);
    arb_rst = 1'b0;
    tick();
    check("cke_rise", sdram_cke, 1'b1);

    // Requests during INIT are ignored
    while (edges < 99) begin
      randomize_ctrl();
      randomize_buses();
      tick();
    end
    init_end = 1'b1;
    {aref_req, aref_end, wr_req, wr_end, rd_end} = '0;
    rd_req = 1'b1;
    tick();
    check("arbit_nop", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {4'b0111, 2'b11, 13'h1fff});
    tick();
    check("rd_grant", rd_en, 1'b1);

    // Refresh raised mid-read waits for rd_end; a stray wr_end is ignored
    wr_sdram_en = 1'b1;
    aref_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_end = (i == 5);
      tick();
      check("rd_hold", rd_en, 1'b1);
      check("rd_no_dq", sdram_dq_oe, 1'b0);
    end
    wr_end = 1'b0;
    rd_end = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    tick();
    check("rd_release", {aref_en, wr_en, rd_en}, 3'b000);
    rd_end = 1'b0;
    tick();
    check("aref_after_rd", aref_en, 1'b1);

    // All three requesting: refresh again, then write after one NOP cycle
    aref_end = 1'b1;
    tick();
    aref_end = 1'b0;
    tick();
    check("aref_regrant", aref_en, 1'b1);
    aref_req = 1'b0; aref_end = 1'b1;
    tick();
    aref_end = 1'b0;
    check("turnaround", {aref_en, wr_en, rd_en}, 3'b000);
    tick();
    check("wr_second", wr_en, 1'b1);

    wr_cmd = 4'b0100; wr_sdram_en = 1'b1; wr_data = 16'hA55A;
    #1;
    check("wr_cmd", {sdram_ras_n, sdram_cas_n, sdram_we_n}, 3'b100);
    check("wr_dq", {sdram_dq_oe, sdram_dq_out}, {1'b1, 16'hA55A});
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    tick();
`ifdef SDRAM_ARB_RR_EN
    check("rr_read", {wr_en, rd_en}, 2'b01);
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    rd_req = 1'b0;
    tick();
`endif
    check("in_write", wr_en, 1'b1);

    // Async reset mid-write drops grant and DQ drive before the next edge
    #2;
    arb_rst = 1'b1;
    #1;
    check("async_wr_en", wr_en, 1'b0);
    check("async_dq_oe", sdram_dq_oe, 1'b0);
    check("async_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {init_cmd, init_bank, init_addr});
    model_reset();
    check_all();
    repeat (2) tick();
    arb_rst = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      randomize_ctrl();
      randomize_buses();
      init_end = ($urandom_range(0, 15) != 0);
      tick();
      if (arb_rst) begin
        arb_rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        arb_rst = 1'b1;
        #1;
        model_reset();
        check_all();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Command arbiter between the SDRAM init, auto-refresh, write and read engines. It holds the bus for the init engine until `init_end`. After that it grants the shared command/bank/address/DQ bus to one engine at a time. Fixed priority is refresh > write > read. It multiplexes the granted engine's `{CS#,RAS#,CAS#,WE#}`, bank, address and write data onto the SDRAM pins.

Parameters:
- DATA_WIDTH, 16, SDRAM DQ width
- ADDR_WIDTH, 13, SDRAM address width (A12..A0)
- BANK_WIDTH, 2, SDRAM bank address width

Ports:
- arb_clk  input  1  arbiter clock (100 MHz, same as SDRAM clock domain)
- arb_rst  input  1  asynchronous, active-high reset
- init_end  input  1  init sequence complete (level)
- init_cmd  input  4  init command {CS#,RAS#,CAS#,WE#}
- init_bank  input  BANK_WIDTH  init bank address
- init_addr  input  ADDR_WIDTH  init address
- aref_req  input  1  auto-refresh request (level, held until granted)
- aref_end  input  1  auto-refresh done, 1-cycle pulse
- aref_cmd/aref_bank/aref_addr  input  4/BANK_WIDTH/ADDR_WIDTH  refresh engine bus
- aref_en  output  1  refresh grant
- wr_req  input  1  write request (level)
- wr_end  input  1  write burst done, 1-cycle pulse
- wr_cmd/wr_bank/wr_addr  input  4/BANK_WIDTH/ADDR_WIDTH  write engine bus
- wr_data  input  DATA_WIDTH  write data
- wr_sdram_en  input  1  write engine drives DQ this cycle
- wr_en  output  1  write grant
- rd_req  input  1  read request (level)
- rd_end  input  1  read burst done, 1-cycle pulse
- rd_cmd/rd_bank/rd_addr  input  4/BANK_WIDTH/ADDR_WIDTH  read engine bus
- rd_en  output  1  read grant
- sdram_cke  output  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each  command pins
- sdram_ba  output  BANK_WIDTH  bank pins
- sdram_addr  output  ADDR_WIDTH  address pins
- sdram_dq_oe  output  1  DQ output enable (1 = drive)
- sdram_dq_out  output  DATA_WIDTH  DQ drive value

Behaviour:
- States: INIT, ARBIT, AREF, WRITE, READ. Registered state with combinational next-state logic.
- Reset (async, arb_rst=1):
  - state=INIT; aref_en=wr_en=rd_en=0; sdram_cke=0; sdram_dq_oe=0; sdram_dq_out=0.
  - Command/bank/address pins follow the init_* inputs.
- sdram_cke is a register, 0 in reset, 1 from the first arb_clk edge after reset release.
- INIT:
  - Pins pass init_cmd/init_bank/init_addr combinationally.
  - All req inputs are ignored.
  - init_end=1 -> ARBIT next cycle.
- ARBIT:
  - Pins = NOP 4'b0111, bank all-ones, address all-ones.
  - Next state by priority: aref_req -> AREF, else wr_req -> WRITE, else rd_req -> READ, else stay.
  - Decision and transition take one cycle: request seen at edge N gives grant high from edge N+1.
- AREF/WRITE/READ:
  - The matching *_en is 1 for every cycle in that state. It is a decoded, glitch-free registered state bit, with no combinational path from req.
  - Pins pass the granted engine's cmd/bank/addr combinationally, with zero latency.
  - The matching *_end=1 -> ARBIT next cycle; *_en drops in the same cycle.
- *_end pulses from a non-granted engine are ignored.
- No preemption: a refresh request raised during WRITE/READ waits until that engine's *_end. Refresh engines must budget the worst-case burst length.
- Minimum turnaround: one NOP cycle (ARBIT) between consecutive grants.
- Back-to-back requests from the same engine are re-granted after that one ARBIT cycle if still highest priority.
- DQ:
  - sdram_dq_oe = wr_sdram_en only in WRITE, else 0.
  - sdram_dq_out = wr_data in WRITE, else 0.
  - Both are combinational from state.
- Illegal state encoding -> ARBIT next cycle if init_end=1, else INIT.
- Reset asserted mid-burst: immediate return to INIT, grants and DQ drive removed asynchronously. The init engine is expected to be reset by the same source.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined:
  - Adds a 1-bit last_grant register, reset = READ, updated on entry to WRITE or READ.
  - In ARBIT with aref_req=0 and wr_req=rd_req=1, the engine not granted last wins. Refresh still has absolute priority.
- Undefined: write always beats read; no extra register.

Test Plan:
- Reset held 5 cycles, init_cmd=4'b0010, init_end=0 -> pins = 0010, cke=0 during reset, cke=1 after first edge post-release, all grants 0.
- init_end rises at cycle 100 -> cycle 101 pins = NOP/bank 2'b11/addr 13'h1fff; rd_req held -> rd_en=1 at cycle 102.
- aref_req, wr_req, rd_req all asserted in the same ARBIT cycle -> aref_en first; after aref_end, one NOP cycle, then wr_en. Read is granted last, or second with SDRAM_ARB_RR_EN if read lost the previous round.
- During WRITE, wr_cmd=4'b0100, wr_sdram_en=1, wr_data=16'hA55A -> sdram_ras_n=1, cas_n=0, we_n=0 same cycle; dq_oe=1; dq_out=16'hA55A. During READ -> dq_oe=0.
- aref_req raised mid-READ and rd_end pulsed 20 cycles later -> rd_en stays 1 for all 20 cycles, aref_en=1 two cycles after rd_end; spurious wr_end during READ has no effect.
- arb_rst asserted mid-WRITE -> wr_en=0 and dq_oe=0 immediately (before next edge); state INIT, pins follow init_*.
